rv32i_mc_ctrl: RTL and testbench

//  Multi-cycle control FSM for the RV32I core. Sequences IMEM fetch, decode,
//  ALU execute, DMEM access and register writeback: drives IR/PC/regfile write

---
 rtl/rv32i_mc_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_rv32i_mc_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle control FSM for the RV32I core: fetch/decode/execute/memory/writeback
// sequencing, memory-wait timeouts, sticky halt/fault and retired-instruction counter.
module rv32i_mc_ctrl #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             halt,
  input  logic             br_taken,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic             regwr,
  output logic             memread,
  output logic             memwrite,
  output logic [1:0]       pc_sel,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic             fault,
  output logic [CNT_W-1:0] instret
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [7:0] WAIT_LIM  = 8'(WAIT_MAX);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic             fault_q, fault_d;
  logic [7:0]       wait_q, wait_d;
  logic [6:0]       op_q, op_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             timeout;

  function automatic logic is_rv32i(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign timeout = (wait_q == WAIT_LIM);

  always_comb begin
    state_d  = state_q;
    fault_d  = fault_q;
    wait_d   = '0;
    op_d     = op_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    ir_wr    = 1'b0;
    pc_wr    = 1'b0;
    regwr    = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    pc_sel   = 2'b00;
    wb_sel   = 2'b00;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        // An ack arriving on the last allowed wait cycle still wins over the timeout.
        if (imem_ack) begin
          ir_wr   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        op_d = opcode;
        if (halt) begin
          state_d = S_HALT;
        end else if (!is_rv32i(opcode)) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        op_d = opcode;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_BRANCH: begin
            pc_wr   = 1'b1;
            pc_sel  = br_taken ? 2'b01 : 2'b00;
            state_d = S_FETCH;
          end
          OP_JAL, OP_JALR, OP_OP, OP_IMM, OP_LUI, OP_AUIPC: state_d = S_WB;
          default: begin
            // FENCE/SYSTEM without a decoder halt retire as no-ops.
            pc_wr   = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        memread  = (op_q == OP_LOAD);
        memwrite = (op_q == OP_STORE);
        if (dmem_ack) begin
          if (op_q == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            pc_wr   = 1'b1;
            state_d = S_FETCH;
          end
        end else if (timeout) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        regwr   = 1'b1;
        pc_wr   = 1'b1;
        state_d = S_FETCH;
        case (op_q)
          OP_LOAD:          wb_sel = 2'b01;
          OP_JAL, OP_JALR:  wb_sel = 2'b10;
          OP_LUI:           wb_sel = 2'b11;
          default:          wb_sel = 2'b00;
        endcase
        case (op_q)
          OP_JAL:  pc_sel = 2'b01;
          OP_JALR: pc_sel = 2'b10;
          default: pc_sel = 2'b00;
        endcase
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  assign instret_d = pc_wr ? instret_q + {{(CNT_W-1){1'b0}}, 1'b1} : instret_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_RST;
      fault_q   <= 1'b0;
      wait_q    <= '0;
      op_q      <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      fault_q   <= fault_d;
      wait_q    <= wait_d;
      op_q      <= op_d;
      instret_q <= instret_d;
    end
  end

  assign state   = state_q;
  assign fault   = fault_q;
  assign instret = instret_q;
endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Bench for rv32i_mc_ctrl: procedural instruction-level model driving random opcodes and
// memory-ack timing, with a per-cycle compare of two instances (32-bit and 4-bit instret).
module tb_rv32i_mc_ctrl;
  localparam int WM = 5;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BR     = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic clk = 1'b0, rst = 1'b0;
  logic [6:0] opcode = '0;
  logic halt = 1'b0, br_taken = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic imem_req, dmem_req, ir_wr, pc_wr, regwr, memread, memwrite, fault;
  logic [1:0] pc_sel, wb_sel;
  logic [2:0] state;
  logic [31:0] instret;
  logic imem_req4, dmem_req4, ir_wr4, pc_wr4, regwr4, memread4, memwrite4, fault4;
  logic [1:0] pc_sel4, wb_sel4;
  logic [2:0] state4;
  logic [3:0] instret4;

  always #5 clk = ~clk;

  rv32i_mc_ctrl #(.WAIT_MAX(WM), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .halt(halt), .br_taken(br_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
    .ir_wr(ir_wr), .pc_wr(pc_wr), .regwr(regwr), .memread(memread), .memwrite(memwrite),
    .pc_sel(pc_sel), .wb_sel(wb_sel), .state(state), .fault(fault), .instret(instret));

  rv32i_mc_ctrl #(.WAIT_MAX(WM), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .halt(halt), .br_taken(br_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req4), .dmem_req(dmem_req4),
    .ir_wr(ir_wr4), .pc_wr(pc_wr4), .regwr(regwr4), .memread(memread4), .memwrite(memwrite4),
    .pc_sel(pc_sel4), .wb_sel(wb_sel4), .state(state4), .fault(fault4), .instret(instret4));

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s @%0t: got %0h want %0h", nm, $time, got, want);
  endtask

  // Expected outputs for the current cycle, written by the model thread.
  bit exp_valid = 1'b0;
  logic [2:0] e_state;
  bit e_ireq, e_dreq, e_irw, e_pcw, e_rgw, e_mr, e_mw, e_fault;
  logic [1:0] e_pcs, e_wbs;
  logic [31:0] e_inst;

  always @(negedge clk) begin
    #2;
    if (exp_valid) begin
      chk("state", 32'(state), 32'(e_state));
      chk("imem_req", 32'(imem_req), 32'(e_ireq));
      chk("dmem_req", 32'(dmem_req), 32'(e_dreq));
      chk("ir_wr", 32'(ir_wr), 32'(e_irw));
      chk("pc_wr", 32'(pc_wr), 32'(e_pcw));
      chk("regwr", 32'(regwr), 32'(e_rgw));
      chk("memread", 32'(memread), 32'(e_mr));
      chk("memwrite", 32'(memwrite), 32'(e_mw));
      chk("pc_sel", 32'(pc_sel), 32'(e_pcs));
      chk("wb_sel", 32'(wb_sel), 32'(e_wbs));
      chk("fault", 32'(fault), 32'(e_fault));
      chk("instret", instret, e_inst);
      chk("cnt4_outs", 32'({imem_req4, dmem_req4, ir_wr4, pc_wr4, regwr4, memread4, memwrite4,
                            pc_sel4, wb_sel4, state4, fault4}),
          32'({e_ireq, e_dreq, e_irw, e_pcw, e_rgw, e_mr, e_mw, e_pcs, e_wbs, e_state, e_fault}));
      chk("cnt4_instret", 32'(instret4), 32'(e_inst[3:0]));
    end
  end

  typedef struct { logic [6:0] op; bit hlt; bit br; } ins_t;
  ins_t dq[$];
  logic [6:0] ops [9] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LOAD, OP_STORE, OP_IMM, OP_OP};
  int lit [13] = '{0, 1, 2, 3, 5, 1, 2, 3, 5, 1, 2, 3, 5};
  bit i_rnd, d_rnd;
  int i_dly, d_dly, cyc, last_fetch;
  int unsigned pct;

  function automatic bit legal(input logic [6:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LOAD, OP_STORE,
                      OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM};
  endfunction

  function automatic logic [1:0] wbsel_of(input logic [6:0] op);
    if (op == OP_LOAD) return 2'b01;
    if (op == OP_JAL || op == OP_JALR) return 2'b10;
    if (op == OP_LUI) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [1:0] pcsel_of(input logic [6:0] op);
    if (op == OP_JAL) return 2'b01;
    if (op == OP_JALR) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit ack_fn(input bit rnd, input int dly, input int w);
    if (rnd) return $urandom_range(0, 99) < pct;
    return w == dly;
  endfunction

  function automatic ins_t pick();
    ins_t t;
    int unsigned r;
    if (dq.size() > 0) return dq.pop_front();
    r = $urandom_range(0, 99);
    t.op = ops[$urandom_range(0, 8)];
    t.hlt = 1'b0;
    t.br = 1'($urandom_range(0, 1));
    if (r < 4) t.hlt = 1'b1;
    else if (r < 8) begin
      t.op = 7'($urandom);
      while (legal(t.op)) t.op = 7'($urandom);
    end
    return t;
  endfunction

  task automatic q(input logic [6:0] op, input bit h, input bit b);
    ins_t t;
    t.op = op; t.hlt = h; t.br = b;
    dq.push_back(t);
  endtask

  task automatic noise();
    halt = 1'($urandom); br_taken = 1'($urandom);
    imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
    opcode = 7'($urandom);
  endtask

  function automatic void e_idle(input logic [2:0] st);
    e_state = st; e_ireq = 0; e_dreq = 0; e_irw = 0; e_pcw = 0; e_rgw = 0;
    e_mr = 0; e_mw = 0; e_pcs = 2'b00; e_wbs = 2'b00;
  endfunction

  task automatic adv();
    @(posedge clk);
    if (e_pcw) e_inst++;
    cyc++;
    @(negedge clk);
  endtask

  // Resets, then walks n instructions phase by phase; entered and left at a falling edge.
  task automatic run_session(input int n, input bit abort);
    ins_t t;
    int w;
    bit dead, ack;
    noise(); rst = 1'b0; e_fault = 0; e_inst = '0; e_idle(3'd0);
    adv(); noise(); adv();
    noise(); rst = 1'b1; e_idle(3'd0); adv();
    dead = 0; cyc = 0;
    for (int k = 0; k < n && !dead; k++) begin
      t = pick();
      w = 0;
      forever begin
        noise(); ack = ack_fn(i_rnd, i_dly, w); imem_ack = ack;
        e_idle(3'd1); e_ireq = 1; e_irw = ack; last_fetch = w + 1;
        adv();
        if (ack) break;
        if (w == WM) begin dead = 1; e_fault = 1; break; end
        w++;
      end
      if (dead) break;
      noise(); opcode = t.op; halt = t.hlt; e_idle(3'd2);
      adv();
      if (t.hlt) begin dead = 1; break; end
      if (!legal(t.op)) begin dead = 1; e_fault = 1; break; end
      noise(); opcode = t.op; br_taken = t.br; e_idle(3'd3);
      if (t.op == OP_BR) begin e_pcw = 1; e_pcs = t.br ? 2'b01 : 2'b00; end
      adv();
      if (t.op == OP_BR) continue;
      if (t.op == OP_LOAD || t.op == OP_STORE) begin
        w = 0;
        forever begin
          noise(); opcode = t.op; ack = ack_fn(d_rnd, d_dly, w); dmem_ack = ack;
          e_idle(3'd4); e_dreq = 1; e_mr = (t.op == OP_LOAD); e_mw = (t.op == OP_STORE);
          if (ack && t.op == OP_STORE) e_pcw = 1;
          if (abort && t.op == OP_STORE && w == 1) begin
            #3 rst = 1'b0;
            #1;
            chk("abort_state", 32'(state), 32'd0);
            chk("abort_memwrite", 32'(memwrite), 32'd0);
            chk("abort_dmem_req", 32'(dmem_req), 32'd0);
            @(negedge clk);
            return;
          end
          adv();
          if (ack) break;
          if (w == WM) begin dead = 1; e_fault = 1; break; end
          w++;
        end
        if (dead || t.op == OP_STORE) continue;
      end
      noise(); opcode = t.op; e_idle(3'd5); e_rgw = 1; e_pcw = 1;
      e_wbs = wbsel_of(t.op); e_pcs = pcsel_of(t.op);
      adv();
    end
    if (dead) repeat (4) begin noise(); e_idle(3'd6); adv(); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1; opcode = OP_IMM; halt = 1'b0; br_taken = 1'b0;
    @(negedge clk); #2;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    @(negedge clk); rst = 1'b1;
    for (int c = 0; c < 13; c++) begin
      #2;
      chk("t1_state", 32'(state), 32'(lit[c]));
      chk("t1_regwr", 32'(regwr), 32'(c % 4 == 0 && c > 0));
      chk("t1_pc_wr", 32'(pc_wr), 32'(c % 4 == 0 && c > 0));
      @(negedge clk);
    end
    chk("t1_instret", instret, 32'd3);
    chk("t1_instret4", 32'(instret4), 32'd3);

    exp_valid = 1'b1;
    i_rnd = 0; d_rnd = 0; i_dly = 0; d_dly = 3; pct = 100;
    q(OP_IMM, 0, 0); q(OP_LOAD, 0, 0); q(OP_BR, 0, 1); q(OP_BR, 0, 0); q(OP_STORE, 0, 0);
    run_session(5, 0);
    chk("mix_cycles", 32'(cyc), 32'd25);
    chk("mix_model_instret", e_inst, 32'd5);
    chk("mix_instret", instret, 32'd5);

    i_dly = 255;
    run_session(1, 0);
    chk("to_fetch_cycles", 32'(last_fetch), 32'(WM + 1));
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_state", 32'(state), 32'd6);

    i_dly = WM; q(OP_IMM, 0, 0);
    run_session(1, 0);
    chk("lastack_cycles", 32'(cyc), 32'(WM + 4));
    chk("lastack_fault", 32'(fault), 32'd0);

    i_dly = 0; q(OP_IMM, 0, 0); q(7'b1111111, 0, 0);
    run_session(3, 0);
    chk("illegal_fault", 32'(fault), 32'd1);
    chk("illegal_instret", instret, 32'd1);

    q(OP_IMM, 0, 0); q(OP_SYSTEM, 1, 0);
    run_session(3, 0);
    chk("ecall_fault", 32'(fault), 32'd0);
    chk("ecall_state", 32'(state), 32'd6);
    chk("ecall_instret", instret, 32'd1);

    d_dly = 3; q(OP_STORE, 0, 0);
    run_session(1, 1);

    for (int k = 0; k < 16; k++) q(OP_IMM, 0, 0);
    run_session(16, 0);
    chk("wrap_instret", instret, 32'd16);
    chk("wrap_instret4", 32'(instret4), 32'd0);

    i_rnd = 1; d_rnd = 1;
    for (int s = 0; s < 40; s++) begin
      pct = (s % 3 == 0) ? 100 : ((s % 3 == 1) ? 60 : 25);
      run_session(int'($urandom_range(5, 30)), 0);
    end
    exp_valid = 1'b0;
    #5;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
